// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch sequencer between the PC register, instruction
// memory and decode.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   pc_in, pc_plus_4_in     current PC and PC+4 from the PC register
//   pc_load_en, pc_next     PC register load strobe and value (combinational)
//   imem_req_*              read request channel (valid/ready), addr = pc_in
//   imem_rsp_*              read response channel (valid only, 1-cycle pulse)
//   redirect_valid/addr     branch/jump redirect from execute
//   instr_valid/ready/data/pc  fetched instruction to decode (registered)
module instr_fetch #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [ADDR_WIDTH-1:0] pc_plus_4_in,
    output logic                  pc_load_en,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  rsp_accept;

    // A response is only used when no redirect makes it stale in the same cycle.
    assign rsp_accept     = (state == WAIT) && imem_rsp_valid && !redirect_valid;

    // Request is suppressed during a redirect so the address never changes under valid.
    assign imem_req_valid = reset && (state == REQ) && !redirect_valid;
    assign imem_req_addr  = pc_in;

    // Redirect has priority over sequential advance.
    assign pc_load_en     = reset && (redirect_valid || rsp_accept);
    assign pc_next        = redirect_valid ? redirect_addr : pc_plus_4_in;

    // State and registered decode outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= REQ;
            req_pc      <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        req_pc <= pc_in;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        // Response in the same cycle is dropped; otherwise it is still in flight.
                        state <= imem_rsp_valid ? REQ : DRAIN;
                    end else if (imem_rsp_valid) begin
                        instr_data  <= imem_rsp_data;
                        instr_pc    <= req_pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid || (instr_valid && instr_ready)) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end
                end
                DRAIN: begin
                    // The stale response ends the drain even if another redirect arrives with it.
                    if (imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer that reads the program counter and fetches from instruction memory. It consumes the current PC and PC+4 from the PC register unit and drives back `pc_load_en`/`pc_next`. It issues one instruction-memory read at a time over a valid/ready request channel and accepts the data on a valid-only response channel. Each fetched instruction is handed to decode over a valid/ready channel, tagged with its PC. It sits between the PC register, instruction memory and decode, and honours branch/jump redirects from execute.

## Interface
- `ADDR_WIDTH`, 24: width of PC, memory address and redirect target.
- `DATA_WIDTH`, 32: instruction width.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low.
- `pc_in`  in  ADDR_WIDTH  current PC from the PC register.
- `pc_plus_4_in`  in  ADDR_WIDTH  `pc_in + 4` from the PC register.
- `pc_load_en`  out  1  PC register load enable (combinational).
- `pc_next`  out  ADDR_WIDTH  value loaded into the PC register (combinational).
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  ADDR_WIDTH  read address, always equal to `pc_in`.
- `imem_rsp_valid`  in  1  read data valid, 1-cycle pulse, no backpressure.
- `imem_rsp_data`  in  DATA_WIDTH  read data.
- `redirect_valid`  in  1  1-cycle redirect request from execute.
- `redirect_addr`  in  ADDR_WIDTH  redirect target.
- `instr_valid`  out  1  instruction valid to decode (registered).
- `instr_ready`  in  1  decode accepts the instruction.
- `instr_data`  out  DATA_WIDTH  instruction (registered).
- `instr_pc`  out  ADDR_WIDTH  PC of `instr_data` (registered).

## Operation
- FSM states: REQ, WAIT, HOLD, DRAIN. Reset state is REQ.
- At most one memory request is outstanding at any time.
- REQ:
  - `imem_req_valid = ~redirect_valid`.
  - On `imem_req_valid & imem_req_ready`: latch `pc_in` into `req_pc` and go to WAIT.
- WAIT: wait for `imem_rsp_valid`. When it arrives with no redirect:
  - `instr_data <= imem_rsp_data`, `instr_pc <= req_pc`, `instr_valid <= 1`.
  - `pc_load_en = 1`, `pc_next = pc_plus_4_in`.
  - Go to HOLD.
- HOLD:
  - `instr_valid` and `instr_data` stay stable until `instr_valid & instr_ready`.
  - On that handshake: `instr_valid <= 0` and go to REQ.
- DRAIN: wait for `imem_rsp_valid`, discard the data, then go to REQ.
- Redirect, any state: `pc_load_en = 1` and `pc_next = redirect_addr`; this takes priority over `pc_plus_4_in`.
  - REQ: `imem_req_valid` is forced low that cycle. Stay in REQ; the next request uses the new PC.
  - WAIT without response: go to DRAIN, because the in-flight response is stale.
  - WAIT with response in the same cycle: drop the response; `instr_valid` stays 0. Go to REQ.
  - HOLD: `instr_valid <= 0` and go to REQ. If `instr_ready` is also high that cycle, the handshake counts as completed.
  - DRAIN: the PC is updated again; stay in DRAIN.
- `pc_load_en` is 0 in all other cycles.
- PC arithmetic is done by the PC register unit. This block never adds; wrap-around of `pc_plus_4_in` at 2^ADDR_WIDTH is passed through unchanged.
- `imem_req_addr` changes while `imem_req_valid` is held only as a result of a redirect. In that case valid drops for the redirect cycle first.

## Timing
- Reset, in any state: state goes to REQ. `instr_valid`, `instr_data` and `instr_pc` are 0. `pc_load_en` is 0 and `imem_req_valid` is 0 during reset.
- A pending response during reset is ignored; memory is reset in the same cycle.
- Request accepted at cycle t, response at t+N (N ≥ 1):
  - `instr_valid` is high from t+N+1.
  - The PC register shows the new PC from t+N+1.
- Decode handshake at cycle h: the next `imem_req_valid` is asserted at h+1.
- Peak throughput with N=1 and `instr_ready` tied high: one instruction every 3 cycles.
- Redirect at cycle r: the request to `redirect_addr` is visible on `imem_req_addr` at r+1, or once DRAIN completes.

## Test plan
- Reset release, PC=0x000000, memory N=1 returning 0x00000013, `instr_ready`=1:
  - Request addr 0x000000 is issued.
  - `instr_valid` with `instr_pc`=0x000000, then the next request at 0x000004.
  - `pc_load_en` pulses once per instruction.
- Backpressure: hold `instr_ready`=0 for 5 cycles with an instruction pending:
  - `instr_data`/`instr_pc` stay stable.
  - No new `imem_req_valid`; `pc_load_en` stays 0.
- `imem_req_ready` low for 3 cycles in REQ: `imem_req_valid` stays high with a constant address, and there is no `pc_load_en`.
- Redirect to 0x000100 during WAIT (N=4):
  - `pc_next`=0x000100 with `pc_load_en`=1.
  - The stale response is discarded with no `instr_valid`.
  - The next request address is 0x000100.
- Redirect to 0x000040 in the same cycle as `imem_rsp_valid`:
  - The response is dropped.
  - `pc_next`=0x000040, not PC+4.
  - The next request goes to 0x000040, with no DRAIN.
- Redirect in HOLD, and reset asserted during WAIT:
  - Redirect in HOLD: `instr_valid` clears the next cycle.
  - Reset during WAIT: all outputs are 0 and the block restarts from REQ.
